sspi: RTL and testbench

- 8/16/32-bit SPI slave (responder), used as the far end of the team's SPI master for loopback and bench use, and as a device-side port.
- Oversamples sck, ss and sdi in the system clock domain. Samples MOSI on rising sck and drives MISO on falling sck, MSB first.
- Supports mode 0 and mode 3 only.
- Presents received words and a done pulse to the host logic, and takes transmit words from the host logic.

---
 rtl/sspi.sv | 168 ++++++++++++++++
 tb/tb_sspi.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sspi.sv
// SPI slave for mode 0 / mode 3 with 8, 16 or 32-bit frames. sck, ss and sdi are oversampled in the clk domain.
// MOSI is sampled on rising sck and MISO is shifted on falling sck, MSB first. Received words are reported with rd_done.
module sspi #(
    parameter bit         CPOL       = 1'b1,
    parameter logic [1:0] BYTE_NUM_1 = 2'd0,
    parameter logic [1:0] BYTE_NUM_2 = 2'd1,
    parameter logic [1:0] BYTE_NUM_4 = 2'd2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  wr_len,
    input  logic [31:0] txdata,
    input  logic        tx_load,
    output logic [31:0] rddata,
    output logic        rd_done,
    output logic        frame_err,
    output logic        busy,
    input  logic        sck,
    input  logic        ss,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_oe
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    function automatic logic [5:0] frame_bits(input logic [1:0] code);
        case (code)
            BYTE_NUM_1: return 6'd8;
            BYTE_NUM_2: return 6'd16;
            BYTE_NUM_4: return 6'd32;
            default:    return 6'd8;
        endcase
    endfunction

    function automatic logic [31:0] len_mask(input logic [5:0] bits);
        case (bits)
            6'd8:    return 32'h0000_00FF;
            6'd16:   return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    logic sck_s1, sck_s2, sck_d;
    logic ss_s1, ss_s2, ss_d;
    logic sdi_s1, sdi_s2, sdi_d;
    logic [1:0] settle;

    // NOTE: asynchronous reset parks each synchronizer at its pin's idle level, so no edge is seen when reset is released.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_s1 <= CPOL;
            sck_s2 <= CPOL;
            sck_d  <= CPOL;
            ss_s1  <= 1'b1;
            ss_s2  <= 1'b1;
            ss_d   <= 1'b1;
            sdi_s1 <= 1'b0;
            sdi_s2 <= 1'b0;
            sdi_d  <= 1'b0;
            settle <= 2'd0;
        end else begin
            // NOTE: non-blocking assignments keep every flop of the chain sampling the previous cycle's value.
            sck_s1 <= sck;
            sck_s2 <= sck_s1;
            sck_d  <= sck_s2;
            ss_s1  <= ss;
            ss_s2  <= ss_s1;
            ss_d   <= ss_s2;
            sdi_s1 <= sdi;
            sdi_s2 <= sdi_s1;
            sdi_d  <= sdi_s2;
            if (settle != 2'd3) settle <= settle + 2'd1;
        end
    end

    logic sck_rise, sck_fall, ss_fall, ss_rise, settled;
    assign sck_rise = sck_s2 & ~sck_d;
    assign sck_fall = ~sck_s2 & sck_d;
    assign ss_fall  = ~ss_s2 & ss_d;
    assign ss_rise  = ss_s2 & ~ss_d;
    // If ss is already low when reset is released, the pipeline would show a false falling edge until it has filled.
    assign settled  = (settle == 2'd3);

    state_t      state;
    logic [31:0] shadow;
    logic [31:0] shift;
    logic [31:0] rx;
    logic [5:0]  bit_cnt;
    logic [5:0]  len;

    logic [5:0]  cnt_next;
    logic [31:0] rx_next;
    // sdi_d is the data level one clk before the detected sck rise, so it is well settled.
    assign cnt_next = bit_cnt + {5'd0, sck_rise};
    assign rx_next  = {rx[30:0], sdi_d};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            rd_done   <= 1'b0;
            frame_err <= 1'b0;
            rddata    <= 32'd0;
            shadow    <= 32'd0;
            shift     <= 32'd0;
            rx        <= 32'd0;
            bit_cnt   <= 6'd0;
            len       <= 6'd8;
        end else begin
            rd_done   <= 1'b0;
            frame_err <= 1'b0;
            if (tx_load) shadow <= txdata;

            case (state)
                ST_IDLE: begin
                    if (ss_fall && settled) begin
                        state   <= ST_SHIFT;
                        busy    <= 1'b1;
                        bit_cnt <= 6'd0;
                        len     <= frame_bits(wr_len);
                        shift   <= shadow;
                        rx      <= 32'd0;
                    end
                end

                ST_SHIFT: begin
                    if (sck_rise) begin
                        rx      <= rx_next;
                        bit_cnt <= cnt_next;
                        if (cnt_next == len) begin
                            rddata  <= rx_next & len_mask(len);
                            rd_done <= 1'b1;
                            state   <= ST_DONE;
                        end
                    end else if (sck_fall && bit_cnt != 6'd0) begin
                        shift <= {shift[30:0], 1'b0};
                    end
                    // A final rise landing together with ss rising still completes the frame.
                    if (ss_rise) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        rx    <= 32'd0;
                        if (cnt_next != 6'd0 && cnt_next != len) frame_err <= 1'b1;
                    end
                end

                ST_DONE: begin
                    if (sck_fall) shift <= 32'd0;
                    if (ss_rise) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

    assign sdo    = shift[31];
    assign sdo_oe = ~ss;

endmodule

// File: tb/tb_sspi.sv
// Directed bench for sspi: a mode-0 and a mode-3 instance driven by a bit-level SPI master model.
// Frames come from a vector table; abort, reset, tx_load and coincident-edge cases are hand-written sequences.
module tb_sspi;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  wr_len = 2'd0;
    logic [31:0] txdata = 32'd0;
    logic        tx_load = 1'b0;
    logic        sdi = 1'b0;
    logic        sck0 = 1'b0, ss0 = 1'b1;
    logic        sck1 = 1'b1, ss1 = 1'b1;

    logic [31:0] rddata0, rddata1;
    logic        rd_done0, rd_done1, frame_err0, frame_err1, busy0, busy1;
    logic        sdo0, sdo1, sdo_oe0, sdo_oe1;

    sspi #(.CPOL(1'b0)) u_m0 (
        .clk(clk), .rst(rst), .wr_len(wr_len), .txdata(txdata), .tx_load(tx_load),
        .rddata(rddata0), .rd_done(rd_done0), .frame_err(frame_err0), .busy(busy0),
        .sck(sck0), .ss(ss0), .sdi(sdi), .sdo(sdo0), .sdo_oe(sdo_oe0)
    );

    sspi #(.CPOL(1'b1)) u_m3 (
        .clk(clk), .rst(rst), .wr_len(wr_len), .txdata(txdata), .tx_load(tx_load),
        .rddata(rddata1), .rd_done(rd_done1), .frame_err(frame_err1), .busy(busy1),
        .sck(sck1), .ss(ss1), .sdi(sdi), .sdo(sdo1), .sdo_oe(sdo_oe1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int last_rise = 0;
    int done_n[2] = '{0, 0};
    int err_n[2] = '{0, 0};
    int done_cyc[2] = '{0, 0};
    int errors = 0;
    int checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rd_done0) begin done_n[0] = done_n[0] + 1; done_cyc[0] = cyc; end
        if (rd_done1) begin done_n[1] = done_n[1] + 1; done_cyc[1] = cyc; end
        if (frame_err0) err_n[0] = err_n[0] + 1;
        if (frame_err1) err_n[1] = err_n[1] + 1;
    end

    typedef struct {
        bit          m3;
        logic [1:0]  len;
        int          nbits;
        logic [31:0] tx;
        logic [31:0] mosi;
        logic [31:0] exp_rd;
        logic [31:0] exp_miso;
        logic        exp_sdo;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_sck(input bit m3, input logic v);
        if (m3) sck1 = v; else sck0 = v;
    endtask

    task automatic set_ss(input bit m3, input logic v);
        if (m3) ss1 = v; else ss0 = v;
    endtask

    function automatic logic get_sdo(input bit m3);
        return m3 ? sdo1 : sdo0;
    endfunction

    function automatic logic [31:0] get_rd(input bit m3);
        return m3 ? rddata1 : rddata0;
    endfunction

    task automatic load(input logic [31:0] v);
        txdata  = v;
        tx_load = 1'b1;
        wait_clk(1);
        tx_load = 1'b0;
    endtask

    // One bit: data set on the falling (or leading) edge, master samples MISO just before the rise.
    task automatic bit_cycle(input bit m3, input logic b, inout logic [31:0] miso);
        set_sck(m3, 1'b0);
        sdi = b;
        wait_clk(HALF);
        miso = {miso[30:0], get_sdo(m3)};
        set_sck(m3, 1'b1);
        last_rise = cyc;
        wait_clk(HALF);
    endtask

    task automatic xfer(input bit m3, input logic [31:0] mosi, input int nbits, output logic [31:0] miso);
        miso = 32'd0;
        set_ss(m3, 1'b0);
        wait_clk(6);
        for (int i = 0; i < nbits; i++) bit_cycle(m3, mosi[31-i], miso);
        if (!m3) begin
            set_sck(m3, 1'b0);
            wait_clk(HALF);
        end
        set_ss(m3, 1'b1);
        wait_clk(8);
    endtask

    initial begin
        logic [31:0] miso;
        logic [31:0] dummy;
        int d0, e0, idx;

        vecs[0] = '{1'b0, 2'd0,  8, 32'hA5FF_0000, 32'h3C00_0000, 32'h0000_003C, 32'h0000_00A5, 1'b0};
        vecs[1] = '{1'b1, 2'd2, 32, 32'h1234_5678, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0};
        vecs[2] = '{1'b0, 2'd1, 16, 32'hC3A5_0000, 32'hBEEF_0000, 32'h0000_BEEF, 32'h0000_C3A5, 1'b0};
        vecs[3] = '{1'b1, 2'd3,  8, 32'h8100_0000, 32'h7E00_0000, 32'h0000_007E, 32'h0000_0081, 1'b1};
        vecs[4] = '{1'b0, 2'd2, 32, 32'h0F0F_1234, 32'h8000_0001, 32'h8000_0001, 32'h0F0F_1234, 1'b0};
        vecs[5] = '{1'b1, 2'd0,  8, 32'hFF00_0000, 32'h0100_0000, 32'h0000_0001, 32'h0000_00FF, 1'b1};

        // Reset state
        wait_clk(3);
        check("reset rddata0", rddata0, 32'd0);
        check("reset rddata1", rddata1, 32'd0);
        check("reset flags0", {29'd0, rd_done0, frame_err0, busy0}, 32'd0);
        check("reset flags1", {29'd0, rd_done1, frame_err1, busy1}, 32'd0);
        check("reset sdo", {30'd0, sdo0, sdo1}, 32'd0);
        check("idle sdo_oe", {30'd0, sdo_oe0, sdo_oe1}, 32'd0);
        rst = 1'b1;
        wait_clk(6);

        // Table-driven frames
        for (int i = 0; i < 6; i++) begin
            idx = vecs[i].m3 ? 1 : 0;
            wr_len = vecs[i].len;
            load(vecs[i].tx);
            d0 = done_n[idx];
            e0 = err_n[idx];
            xfer(vecs[i].m3, vecs[i].mosi, vecs[i].nbits, miso);
            check($sformatf("v%0d rddata", i), get_rd(vecs[i].m3), vecs[i].exp_rd);
            check($sformatf("v%0d miso", i), miso, vecs[i].exp_miso);
            check($sformatf("v%0d rd_done count", i), 32'(done_n[idx] - d0), 32'd1);
            check($sformatf("v%0d frame_err count", i), 32'(err_n[idx] - e0), 32'd0);
            check($sformatf("v%0d done latency", i), 32'(done_cyc[idx] - last_rise), 32'd3);
            check($sformatf("v%0d sdo after frame", i), {31'd0, get_sdo(vecs[i].m3)}, {31'd0, vecs[i].exp_sdo});
        end

        // Back-to-back 16-bit frames without tx_load repeat the same tx word
        wr_len = 2'd1;
        load(32'h9A7E_0000);
        xfer(1'b0, 32'hBEEF_0000, 16, miso);
        check("b2b first rddata", rddata0, 32'h0000_BEEF);
        check("b2b first miso", miso, 32'h0000_9A7E);
        xfer(1'b0, 32'h1234_0000, 16, miso);
        check("b2b second rddata", rddata0, 32'h0000_1234);
        check("b2b second miso", miso, 32'h0000_9A7E);

        // ss low with no sck edges: busy and sdo_oe follow ss, no frame_err
        e0 = err_n[0];
        ss0 = 1'b0;
        wait_clk(6);
        check("busy while selected", {31'd0, busy0}, 32'd1);
        check("sdo_oe while selected", {31'd0, sdo_oe0}, 32'd1);
        check("sdo first bit", {31'd0, sdo0}, 32'd1);
        ss0 = 1'b1;
        wait_clk(6);
        check("busy after deselect", {31'd0, busy0}, 32'd0);
        check("empty frame no error", 32'(err_n[0] - e0), 32'd0);

        // Abort after 5 bits of a 16-bit frame
        d0 = done_n[0];
        e0 = err_n[0];
        xfer(1'b0, 32'hA5A5_0000, 5, miso);
        check("abort frame_err count", 32'(err_n[0] - e0), 32'd1);
        check("abort rd_done count", 32'(done_n[0] - d0), 32'd0);
        check("abort rddata held", rddata0, 32'h0000_1234);

        // tx_load mid-frame affects only the next frame
        wr_len = 2'd0;
        load(32'hF000_0000);
        fork
            xfer(1'b0, 32'h1100_0000, 8, miso);
            begin
                wait_clk(40);
                load(32'h5500_0000);
            end
        join
        check("midload current miso", miso, 32'h0000_00F0);
        check("midload rddata", rddata0, 32'h0000_0011);
        xfer(1'b0, 32'h2200_0000, 8, miso);
        check("midload next miso", miso, 32'h0000_0055);

        // ss rising together with the 8th rising sck
        d0 = done_n[0];
        e0 = err_n[0];
        miso = 32'd0;
        ss0 = 1'b0;
        wait_clk(6);
        for (int i = 0; i < 7; i++) bit_cycle(1'b0, 1'(8'hC5 >> (7 - i)), miso);
        sck0 = 1'b0;
        sdi = 1'b1;
        wait_clk(HALF);
        sck0 = 1'b1;
        ss0 = 1'b1;
        wait_clk(12);
        sck0 = 1'b0;
        wait_clk(8);
        check("coincident rddata", rddata0, 32'h0000_00C5);
        check("coincident rd_done count", 32'(done_n[0] - d0), 32'd1);
        check("coincident frame_err count", 32'(err_n[0] - e0), 32'd0);

        // Reset after bit 3 of a 32-bit frame, then a clean 8-bit frame
        wr_len = 2'd2;
        dummy = 32'd0;
        ss0 = 1'b0;
        wait_clk(6);
        bit_cycle(1'b0, 1'b1, dummy);
        bit_cycle(1'b0, 1'b0, dummy);
        bit_cycle(1'b0, 1'b1, dummy);
        rst = 1'b0;
        wait_clk(1);
        check("midrst rddata", rddata0, 32'd0);
        check("midrst flags", {28'd0, rd_done0, frame_err0, busy0, sdo0}, 32'd0);
        check("midrst rddata1", rddata1, 32'd0);
        wait_clk(3);
        rst = 1'b1;
        d0 = done_n[0];
        e0 = err_n[0];
        wait_clk(2);
        for (int i = 0; i < 4; i++) bit_cycle(1'b0, 1'b1, dummy);
        check("post-reset edges ignored busy", {31'd0, busy0}, 32'd0);
        sck0 = 1'b0;
        wait_clk(HALF);
        ss0 = 1'b1;
        wait_clk(8);
        check("post-reset no frame_err", 32'(err_n[0] - e0), 32'd0);
        check("post-reset no rd_done", 32'(done_n[0] - d0), 32'd0);
        wr_len = 2'd0;
        xfer(1'b0, 32'h6B00_0000, 8, miso);
        check("post-reset rddata", rddata0, 32'h0000_006B);
        check("post-reset rd_done count", 32'(done_n[0] - d0), 32'd1);
        check("post-reset miso from cleared shadow", miso, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
